lif_neuron_scheduler: RTL

Time-multiplexes one shared combinational LIF `neuron` datapath across `N_NEURONS` virtual neurons. Per-neuron weights, membrane and previous-spike flag live in local register files. Input spikes, threshold and leak shift are shared by all neurons. On each `tick` the block walks every neuron through the datapath, one per cycle, writes the results back, and publishes a spike vector with a `done` pulse. It sits between the top-level byte-wide pin interface and the `neuron` instance.

---
 rtl/lif_neuron_scheduler_if.sv | 27 ++
 rtl/lif_neuron_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lif_neuron_scheduler_if.sv
// Configuration byte channel into the LIF neuron scheduler.
// The master offers bytes; the scheduler, as the slave, accepts them while it is idle.
interface lif_neuron_scheduler_if #(
    parameter int SEL_BITS = 2
) ();
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_kind;
    logic [SEL_BITS-1:0] cfg_sel;
    logic [7:0]          cfg_data;

    modport master (
        output cfg_valid,
        output cfg_kind,
        output cfg_sel,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_kind,
        input  cfg_sel,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// Shares one combinational LIF neuron datapath across N_NEURONS virtual neurons.
// Each tick walks every neuron through the datapath once and then publishes the spike vector.
module lif_neuron_scheduler #(
    parameter int N_STAGES       = 4,
    parameter int N_NEURONS      = 4,
    parameter int MEMBRANE_BITS  = N_STAGES + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    lif_neuron_scheduler_if.slave           cfg,
    input  logic                            tick_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [N_NEURONS-1:0]            spikes_o,
    output logic [2**N_STAGES-1:0]          dp_inputs_o,
    output logic [2**N_STAGES-1:0]          dp_weights_o,
    output logic [2:0]                      dp_shift_o,
    output logic [THRESHOLD_BITS-1:0]       dp_threshold_o,
    output logic signed [MEMBRANE_BITS-1:0] dp_last_membrane_o,
    output logic                            dp_was_spike_o,
    input  logic signed [MEMBRANE_BITS-1:0] dp_new_membrane_i,
    input  logic                            dp_is_spike_i
);
    localparam int INPUTS = 2**N_STAGES;
    localparam int SEL_BITS = $clog2(N_NEURONS);
    localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(N_NEURONS - 1);

    localparam logic [1:0] KIND_WEIGHTS   = 2'b00;
    localparam logic [1:0] KIND_INPUTS    = 2'b01;
    localparam logic [1:0] KIND_THRESHOLD = 2'b10;
    localparam logic [1:0] KIND_SHIFT     = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [SEL_BITS-1:0]               idx_q, idx_d;
    logic [INPUTS-1:0]                 weights_q [N_NEURONS];
    logic [INPUTS-1:0]                 weights_d [N_NEURONS];
    logic signed [MEMBRANE_BITS-1:0]   membrane_q [N_NEURONS];
    logic signed [MEMBRANE_BITS-1:0]   membrane_d [N_NEURONS];
    logic [N_NEURONS-1:0]              was_spike_q, was_spike_d;
    logic [N_NEURONS-1:0]              accum_q, accum_d;
    logic [N_NEURONS-1:0]              spikes_q, spikes_d;
    logic [INPUTS-1:0]                 inputs_q, inputs_d;
    logic [THRESHOLD_BITS-1:0]         threshold_q, threshold_d;
    logic [2:0]                        shift_q, shift_d;

    // Wide registers are loaded MSB byte first; narrow ones keep only the low bits of the byte.
    function automatic logic [INPUTS-1:0] shiftInByte(input logic [INPUTS-1:0] cur,
                                                      input logic [7:0] b);
        logic [INPUTS+7:0] joined;
        joined = {cur, b};
        return joined[INPUTS-1:0];
    endfunction

    assign cfg.cfg_ready = (state_q == IDLE) && !tick_i;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        weights_d   = weights_q;
        membrane_d  = membrane_q;
        was_spike_d = was_spike_q;
        accum_d     = accum_q;
        spikes_d    = spikes_q;
        inputs_d    = inputs_q;
        threshold_d = threshold_q;
        shift_d     = shift_q;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (tick_i) begin
                    state_d = RUN;
                end else if (cfg.cfg_valid) begin
                    unique case (cfg.cfg_kind)
                        KIND_WEIGHTS:   weights_d[cfg.cfg_sel] = shiftInByte(weights_q[cfg.cfg_sel], cfg.cfg_data);
                        KIND_INPUTS:    inputs_d = shiftInByte(inputs_q, cfg.cfg_data);
                        KIND_THRESHOLD: threshold_d = cfg.cfg_data[THRESHOLD_BITS-1:0];
                        KIND_SHIFT: begin
                            shift_d = cfg.cfg_data[2:0];
                            if (cfg.cfg_data[7]) begin
                                for (int i = 0; i < N_NEURONS; i++) begin
                                    membrane_d[i] = '0;
                                end
                                was_spike_d = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                membrane_d[idx_q]  = dp_new_membrane_i;
                was_spike_d[idx_q] = dp_is_spike_i;
                accum_d[idx_q]     = dp_is_spike_i;
                // The last neuron's spike joins the published vector on the same edge it is computed.
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    spikes_d = accum_d;
                end else begin
                    idx_d = idx_q + SEL_BITS'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                weights_q[i]  <= '1;
                membrane_q[i] <= '0;
            end
            was_spike_q <= '0;
            accum_q     <= '0;
            spikes_q    <= '0;
            inputs_q    <= '0;
            threshold_q <= THRESHOLD_BITS'(5);
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            weights_q   <= weights_d;
            membrane_q  <= membrane_d;
            was_spike_q <= was_spike_d;
            accum_q     <= accum_d;
            spikes_q    <= spikes_d;
            inputs_q    <= inputs_d;
            threshold_q <= threshold_d;
            shift_q     <= shift_d;
        end
    end

    assign busy_o             = (state_q != IDLE);
    assign done_o             = (state_q == DONE);
    assign spikes_o           = spikes_q;
    assign dp_inputs_o        = inputs_q;
    assign dp_weights_o       = weights_q[idx_q];
    assign dp_shift_o         = shift_q;
    assign dp_threshold_o     = threshold_q;
    assign dp_last_membrane_o = membrane_q[idx_q];
    assign dp_was_spike_o     = was_spike_q[idx_q];
endmodule
